// File: rtl/sblk_row_sched_if.sv
// +--------------------------------------------------------------------------+
// | sblk_row_sched_if : config, row-control and activation-stream bundle     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sblk_row_sched_if #(
  parameter int NUM_ROW   = 4,
  parameter int PARAM_LEN = 64,
  parameter int DATA_LEN  = 32
);
  localparam int IDX_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

  logic [PARAM_LEN-1:0] cfg_param;
  logic                 cfg_vld;
  logic                 cfg_rdy;
  logic [PARAM_LEN-1:0] row_param;
  logic [NUM_ROW-1:0]   row_param_en;
  logic [NUM_ROW-1:0]   row_status;
  logic [NUM_ROW-1:0]   row_wr_req;
  logic [NUM_ROW-1:0]   row_wr_vld;
  logic [DATA_LEN-1:0]  row_wr_data;
  logic [DATA_LEN-1:0]  src_data;
  logic                 src_vld;
  logic                 src_rdy;
  logic [IDX_W-1:0]     src_row;
  logic                 layer_done;
  logic [15:0]          layer_cnt;
  logic                 sched_busy;
  logic                 start_err;

  // master: the scheduler; slave: controller, fetch logic and rows around it
  modport master (
    input  cfg_param, cfg_vld, row_status, row_wr_req, src_data, src_vld,
    output cfg_rdy, row_param, row_param_en, row_wr_vld, row_wr_data,
           src_rdy, src_row, layer_done, layer_cnt, sched_busy, start_err
  );

  modport slave (
    output cfg_param, cfg_vld, row_status, row_wr_req, src_data, src_vld,
    input  cfg_rdy, row_param, row_param_en, row_wr_vld, row_wr_data,
           src_rdy, src_row, layer_done, layer_cnt, sched_busy, start_err
  );
endinterface

`default_nettype wire

// File: rtl/sblk_row_sched.sv
// +--------------------------------------------------------------------------+
// | sblk_row_sched : layer-parameter broadcast, row busy tracking and        |
// |                  round-robin routing of the shared activation stream     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module sblk_row_sched #(
  parameter int NUM_ROW   = 4,
  parameter int PARAM_LEN = 64,
  parameter int DATA_LEN  = 32,
  parameter int START_TO  = 15
) (
  input  wire logic          clk_l,
  input  wire logic          rst_n,
  sblk_row_sched_if.master   bus
);
  localparam int IDX_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int CNT_W = $clog2(START_TO + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   idx_ext_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    RUN        = 3'd3,
    DONE       = 3'd4
  } state_e;

  state_e               state_q, state_d;
  cnt_t                 cnt_q, cnt_d;
  logic [PARAM_LEN-1:0] row_param_q;
  logic                 start_err_q, start_err_d;
  logic                 layer_done_q, layer_done_d;
  logic [15:0]          layer_cnt_q, layer_cnt_d;
  logic                 cfg_rdy_w;
  logic [NUM_ROW-1:0]   param_en_w;

  idx_t                 ptr_q, ptr_d;
  logic [NUM_ROW-1:0]   wr_vld_q, wr_vld_d;
  logic [DATA_LEN-1:0]  wr_data_q, wr_data_d;
  idx_t                 grant_w;
  idx_ext_t             idx_w;
  logic                 found_w;
  logic                 src_rdy_w;
  logic                 beat_acc_w;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_err_d  = start_err_q;
    layer_done_d = 1'b0;
    layer_cnt_d  = layer_cnt_q;
    cfg_rdy_w    = 1'b0;
    param_en_w   = '0;
    case (state_q)
      IDLE: begin
        cfg_rdy_w = bus.cfg_vld && (bus.row_status == '0);
        if (cfg_rdy_w) state_d = ISSUE;
      end
      ISSUE: begin
        param_en_w = '1;
        cnt_d      = '0;
        state_d    = WAIT_START;
      end
      WAIT_START: begin
        if (&bus.row_status) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
          if (cnt_d == cnt_t'(START_TO)) begin
            start_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      RUN: begin
        if (bus.row_status == '0) state_d = DONE;
      end
      DONE: begin
        // done pulse and count are registered, so they land in the following IDLE cycle
        layer_done_d = 1'b1;
        layer_cnt_d  = layer_cnt_q + 16'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_param_q  <= '0;
      start_err_q  <= 1'b0;
      layer_done_q <= 1'b0;
      layer_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_err_q  <= start_err_d;
      layer_done_q <= layer_done_d;
      layer_cnt_q  <= layer_cnt_d;
      if (cfg_rdy_w) row_param_q <= bus.cfg_param;
    end
  end

  // first requester at or after the pointer, wrapping past the last row
  always_comb begin
    grant_w = '0;
    found_w = 1'b0;
    idx_w   = '0;
    for (int i = 0; i < NUM_ROW; i++) begin
      idx_w = idx_ext_t'(ptr_q) + idx_ext_t'(i);
      if (idx_w >= idx_ext_t'(NUM_ROW)) idx_w = idx_w - idx_ext_t'(NUM_ROW);
      if (!found_w && bus.row_wr_req[idx_w[IDX_W-1:0]]) begin
        grant_w = idx_w[IDX_W-1:0];
        found_w = 1'b1;
      end
    end
  end

  assign src_rdy_w  = |bus.row_wr_req;
  assign beat_acc_w = bus.src_vld && src_rdy_w;

  always_comb begin
    ptr_d     = ptr_q;
    wr_vld_d  = '0;
    wr_data_d = wr_data_q;
    if (beat_acc_w) begin
      wr_vld_d[grant_w] = 1'b1;
      wr_data_d         = bus.src_data;
      ptr_d             = (grant_w == idx_t'(NUM_ROW - 1)) ? '0 : grant_w + idx_t'(1);
    end
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      wr_vld_q  <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_vld_q  <= wr_vld_d;
      wr_data_q <= wr_data_d;
    end
  end

  // combinational handshakes are forced low while reset is held
  assign bus.cfg_rdy      = rst_n && cfg_rdy_w;
  assign bus.src_rdy      = rst_n && src_rdy_w;
  assign bus.src_row      = rst_n ? grant_w : '0;
  assign bus.row_param    = row_param_q;
  assign bus.row_param_en = param_en_w;
  assign bus.row_wr_vld   = wr_vld_q;
  assign bus.row_wr_data  = wr_data_q;
  assign bus.layer_done   = layer_done_q;
  assign bus.layer_cnt    = layer_cnt_q;
  assign bus.sched_busy   = (state_q != IDLE);
  assign bus.start_err    = start_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sblk_row_sched.sv
// +--------------------------------------------------------------------------+
// | tb_sblk_row_sched : directed bench for the row scheduler                 |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sblk_row_sched;
  logic clk_l = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk_l = ~clk_l;

  sblk_row_sched_if #(.NUM_ROW(4), .PARAM_LEN(64), .DATA_LEN(32)) bus ();

  sblk_row_sched #(.NUM_ROW(4), .PARAM_LEN(64), .DATA_LEN(32), .START_TO(15)) dut (
    .clk_l (clk_l),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  req;
    logic        vld;
    logic [31:0] data;
    logic        e_rdy;
    logic        chk_row;
    logic [1:0]  e_row;
    logic [3:0]  e_wvld;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk_l);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " cfg_rdy"},      64'(bus.cfg_rdy),      64'h0);
    chk({tag, " row_param"},    bus.row_param,         64'h0);
    chk({tag, " row_param_en"}, 64'(bus.row_param_en), 64'h0);
    chk({tag, " row_wr_vld"},   64'(bus.row_wr_vld),   64'h0);
    chk({tag, " row_wr_data"},  64'(bus.row_wr_data),  64'h0);
    chk({tag, " layer_done"},   64'(bus.layer_done),   64'h0);
    chk({tag, " layer_cnt"},    64'(bus.layer_cnt),    64'h0);
    chk({tag, " start_err"},    64'(bus.start_err),    64'h0);
    chk({tag, " sched_busy"},   64'(bus.sched_busy),   64'h0);
    chk({tag, " src_rdy"},      64'(bus.src_rdy),      64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // req, vld, data, e_rdy, chk_row, e_row, e_wvld, e_wdata  (pointer starts at 0)
    tbl[0]  = '{4'hF, 1'b1, 32'h0000_00D0, 1'b1, 1'b1, 2'd0, 4'h1, 32'h0000_00D0};
    tbl[1]  = '{4'hF, 1'b1, 32'h0000_00D1, 1'b1, 1'b1, 2'd1, 4'h2, 32'h0000_00D1};
    tbl[2]  = '{4'hF, 1'b1, 32'h0000_00D2, 1'b1, 1'b1, 2'd2, 4'h4, 32'h0000_00D2};
    tbl[3]  = '{4'hF, 1'b1, 32'h0000_00D3, 1'b1, 1'b1, 2'd3, 4'h8, 32'h0000_00D3};
    tbl[4]  = '{4'hF, 1'b1, 32'h0000_00D4, 1'b1, 1'b1, 2'd0, 4'h1, 32'h0000_00D4};
    tbl[5]  = '{4'hF, 1'b1, 32'h0000_00D5, 1'b1, 1'b1, 2'd1, 4'h2, 32'h0000_00D5};
    tbl[6]  = '{4'hF, 1'b1, 32'h0000_00D6, 1'b1, 1'b1, 2'd2, 4'h4, 32'h0000_00D6};
    tbl[7]  = '{4'hF, 1'b1, 32'h0000_00D7, 1'b1, 1'b1, 2'd3, 4'h8, 32'h0000_00D7};
    tbl[8]  = '{4'hA, 1'b1, 32'h0000_00E0, 1'b1, 1'b1, 2'd1, 4'h2, 32'h0000_00E0};
    tbl[9]  = '{4'hA, 1'b1, 32'h0000_00E1, 1'b1, 1'b1, 2'd3, 4'h8, 32'h0000_00E1};
    tbl[10] = '{4'hA, 1'b1, 32'h0000_00E2, 1'b1, 1'b1, 2'd1, 4'h2, 32'h0000_00E2};
    tbl[11] = '{4'h2, 1'b1, 32'h0000_00E3, 1'b1, 1'b1, 2'd1, 4'h2, 32'h0000_00E3};
    tbl[12] = '{4'h0, 1'b1, 32'h0000_00E4, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0000_00E3};
    tbl[13] = '{4'hF, 1'b0, 32'h0000_00E5, 1'b1, 1'b1, 2'd2, 4'h0, 32'h0000_00E3};
    tbl[14] = '{4'hF, 1'b1, 32'h0000_00E6, 1'b1, 1'b1, 2'd2, 4'h4, 32'h0000_00E6};
    tbl[15] = '{4'h1, 1'b1, 32'h0000_00E7, 1'b1, 1'b1, 2'd0, 4'h1, 32'h0000_00E7};
    tbl[16] = '{4'h1, 1'b1, 32'h0000_00E8, 1'b1, 1'b1, 2'd0, 4'h1, 32'h0000_00E8};

    bus.cfg_param  = '0;
    bus.cfg_vld    = 1'b0;
    bus.row_status = '0;
    bus.row_wr_req = '0;
    bus.src_data   = '0;
    bus.src_vld    = 1'b0;

    #3;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      bus.row_wr_req = tbl[i].req;
      bus.src_vld    = tbl[i].vld;
      bus.src_data   = tbl[i].data;
      #1;
      chk($sformatf("arb[%0d] src_rdy", i), 64'(bus.src_rdy), 64'(tbl[i].e_rdy));
      if (tbl[i].chk_row)
        chk($sformatf("arb[%0d] src_row", i), 64'(bus.src_row), 64'(tbl[i].e_row));
      step();
      chk($sformatf("arb[%0d] row_wr_vld", i), 64'(bus.row_wr_vld), 64'(tbl[i].e_wvld));
      chk($sformatf("arb[%0d] row_wr_data", i), 64'(bus.row_wr_data), 64'(tbl[i].e_wdata));
    end
    bus.row_wr_req = '0;
    bus.src_vld    = 1'b0;
    step();
    chk("arb idle row_wr_vld", 64'(bus.row_wr_vld), 64'h0);

    // single layer: rows busy two cycles after the load strobe, idle 20 cycles later
    bus.cfg_param = 64'hA5;
    bus.cfg_vld   = 1'b1;
    #1;
    chk("L1 cfg_rdy accept", 64'(bus.cfg_rdy), 64'h1);
    step();
    bus.cfg_vld = 1'b0;
    chk("L1 row_param_en", 64'(bus.row_param_en), 64'hF);
    chk("L1 row_param", bus.row_param, 64'hA5);
    chk("L1 sched_busy", 64'(bus.sched_busy), 64'h1);
    chk("L1 cfg_rdy issue", 64'(bus.cfg_rdy), 64'h0);
    step();
    chk("L1 row_param_en one cycle", 64'(bus.row_param_en), 64'h0);
    step();
    bus.row_status = 4'hF;
    step();
    for (int i = 0; i < 20; i++) step();
    chk("L1 no early layer_done", 64'(bus.layer_done), 64'h0);
    chk("L1 row_param stable", bus.row_param, 64'hA5);
    bus.row_status = 4'h0;
    step();
    chk("L1 layer_done +1", 64'(bus.layer_done), 64'h0);
    step();
    chk("L1 layer_done +2", 64'(bus.layer_done), 64'h1);
    chk("L1 layer_cnt", 64'(bus.layer_cnt), 64'h1);
    chk("L1 sched_busy idle", 64'(bus.sched_busy), 64'h0);
    step();
    chk("L1 layer_done pulse end", 64'(bus.layer_done), 64'h0);

    // back-pressure while one row is still busy
    bus.row_status = 4'b0100;
    bus.cfg_param  = 64'h1234;
    bus.cfg_vld    = 1'b1;
    #1;
    chk("BP cfg_rdy busy row", 64'(bus.cfg_rdy), 64'h0);
    step();
    step();
    step();
    chk("BP cfg_rdy held", 64'(bus.cfg_rdy), 64'h0);
    chk("BP sched_busy", 64'(bus.sched_busy), 64'h0);
    bus.row_status = 4'h0;
    #1;
    chk("BP cfg_rdy release", 64'(bus.cfg_rdy), 64'h1);
    step();
    bus.cfg_vld = 1'b0;
    chk("BP row_param_en", 64'(bus.row_param_en), 64'hF);
    chk("BP row_param", bus.row_param, 64'h1234);
    bus.row_status = 4'hF;
    step();
    step();
    // new word offered across DONE: accepted only in the IDLE cycle after it
    bus.row_status = 4'h0;
    bus.cfg_param  = 64'hBEEF;
    bus.cfg_vld    = 1'b1;
    #1;
    chk("BP cfg_rdy in RUN", 64'(bus.cfg_rdy), 64'h0);
    step();
    chk("BP cfg_rdy in DONE", 64'(bus.cfg_rdy), 64'h0);
    step();
    chk("BP layer_done", 64'(bus.layer_done), 64'h1);
    chk("BP layer_cnt", 64'(bus.layer_cnt), 64'h2);
    chk("BP cfg_rdy after DONE", 64'(bus.cfg_rdy), 64'h1);
    step();
    bus.cfg_vld = 1'b0;
    chk("TO row_param_en", 64'(bus.row_param_en), 64'hF);
    chk("TO row_param", bus.row_param, 64'hBEEF);

    // start timeout: row 3 never reports busy
    bus.row_status = 4'b0111;
    for (int i = 0; i < 15; i++) step();
    chk("TO busy last wait", 64'(bus.sched_busy), 64'h1);
    chk("TO err not yet", 64'(bus.start_err), 64'h0);
    step();
    chk("TO start_err", 64'(bus.start_err), 64'h1);
    chk("TO back to idle", 64'(bus.sched_busy), 64'h0);
    chk("TO layer_cnt kept", 64'(bus.layer_cnt), 64'h2);
    bus.cfg_param = 64'h77;
    bus.cfg_vld   = 1'b1;
    #1;
    chk("TO cfg_rdy rows busy", 64'(bus.cfg_rdy), 64'h0);
    bus.row_status = 4'h0;
    #1;
    chk("TO cfg_rdy next", 64'(bus.cfg_rdy), 64'h1);
    step();
    bus.cfg_vld = 1'b0;
    chk("TO row_param next", bus.row_param, 64'h77);
    chk("TO start_err sticky", 64'(bus.start_err), 64'h1);
    bus.row_status = 4'hF;
    step();
    step();
    chk("RST in RUN", 64'(bus.sched_busy), 64'h1);

    // beat in flight, then asynchronous reset mid-cycle
    bus.row_wr_req = 4'hF;
    bus.src_vld    = 1'b1;
    bus.src_data   = 32'hCAFE;
    #1;
    chk("RST pre src_row", 64'(bus.src_row), 64'h1);
    step();
    chk("RST inflight vld", 64'(bus.row_wr_vld), 64'h2);
    chk("RST inflight data", 64'(bus.row_wr_data), 64'hCAFE);
    bus.row_status = 4'h0;
    bus.cfg_vld    = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async rst");
    step();
    chk("RST held layer_cnt", 64'(bus.layer_cnt), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("RST ptr zero", 64'(bus.src_row), 64'h0);
    chk("RST idle cfg_rdy", 64'(bus.cfg_rdy), 64'h1);
    chk("RST idle busy", 64'(bus.sched_busy), 64'h0);
    bus.cfg_vld    = 1'b0;
    bus.src_vld    = 1'b0;
    bus.row_wr_req = '0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/sblk_row_sched.md
Name: sblk_row_sched

Overview:
- Sequences the array of sblk conv rows, one instance per HW_D3 position.
- Accepts layer parameter words from the top-level controller, broadcasts each word to all rows, and tracks each row's busy status until the layer completes.
- Arbitrates the single shared activation write stream between the rows' write requests using round-robin.
- Sits between the top-level config/activation fetch logic and the sblk_conv_row instances. Runs entirely on clk_l.

Parameters:
- NUM_ROW, 4, number of conv rows scheduled (HW_D3).
- PARAM_LEN, 64, width of one layer parameter word (HW_XLT_LEN).
- DATA_LEN, 32, width of one activation write beat (2*ACTBUF_DATA_LEN).
- START_TO, 15, max cycles allowed after the parameter pulse for all rows to report busy.

Ports:
- clk_l, input, 1, block clock.
- rst_n, input, 1, asynchronous active-low reset.
- cfg_param, input, PARAM_LEN, layer parameter word.
- cfg_vld, input, 1, cfg_param valid.
- cfg_rdy, output, 1, cfg_param accepted this cycle.
- row_param, output, PARAM_LEN, parameter word broadcast to all rows.
- row_param_en, output, NUM_ROW, per-row parameter load strobe.
- row_status, input, NUM_ROW, per-row busy flag (1 = busy).
- row_wr_req, input, NUM_ROW, per-row activation write request.
- row_wr_vld, output, NUM_ROW, one-hot activation beat valid to the granted row.
- row_wr_data, output, DATA_LEN, activation beat, shared by all rows.
- src_data, input, DATA_LEN, activation beat from fetch logic.
- src_vld, input, 1, src_data valid.
- src_rdy, output, 1, beat accepted when src_vld and src_rdy are both high.
- src_row, output, clog2(NUM_ROW), index of the row the current beat targets.
- layer_done, output, 1, one-cycle pulse when all rows return idle.
- layer_cnt, output, 16, completed layers, wraps at 16'hFFFF to 0.
- sched_busy, output, 1, high in every state except IDLE.
- start_err, output, 1, sticky start-timeout error.

Behaviour:
- Reset (async, rst_n low) sets these values:
  - FSM = IDLE.
  - All outputs 0, including cfg_rdy, row_param, row_param_en, row_wr_vld, row_wr_data, layer_done, layer_cnt, start_err, sched_busy.
  - Round-robin pointer = 0, timeout counter = 0.
  - Reset mid-layer drops any in-flight beat silently.
- FSM states: IDLE, ISSUE, WAIT_START, RUN, DONE.
- IDLE:
  - cfg_rdy = cfg_vld && (row_status == 0). This is combinational.
  - On accept, latch cfg_param into row_param and go to ISSUE.
  - If cfg_vld is high while any row is busy, wait; cfg_rdy stays low.
- ISSUE (1 cycle):
  - row_param_en = all ones for exactly this cycle. row_param is stable from this cycle until the next accept.
  - Clear the timeout counter and go to WAIT_START.
- WAIT_START:
  - When row_status is all ones, go to RUN.
  - Otherwise increment the counter each cycle. When the counter reaches START_TO, set start_err and go to IDLE. layer_cnt does not change.
  - start_err clears only on reset.
- RUN: when row_status == 0, go to DONE.
- DONE (1 cycle): layer_done = 1, layer_cnt += 1, then go to IDLE.
- cfg_rdy is 0 in every state except IDLE.
- Latency: cfg accept to row_param_en is 1 cycle. All rows idle in RUN to layer_done is 2 cycles.
- Arbitration runs independently of the FSM; requests are honoured in any state.
  - Grant = first asserted row_wr_req at or after the pointer, searching upward and wrapping from NUM_ROW-1 to 0.
  - src_row = grant index. src_rdy = |row_wr_req. Both are combinational.
  - When src_vld && src_rdy: the next cycle drives row_wr_vld[grant] = 1 (only that bit) and row_wr_data = src_data. The pointer becomes grant+1, wrapping.
  - With no accept, row_wr_vld = 0, row_wr_data holds its last value, and the pointer holds.
  - If the pointed-at row drops its request, grant moves to the next requester in the same cycle. No beat is ever routed to a non-requesting row.
  - If src_vld is high with no requests, src_rdy = 0 and the beat stays pending upstream.
- Simultaneous events:
  - A cfg accept and a beat accept in the same cycle are independent.
  - layer_done and a new cfg_vld: the new word is accepted in the IDLE cycle that follows DONE, no earlier.

Test Plan:
- Reset then single layer:
  - Stimulus: cfg_param=64'hA5, cfg_vld; rows go busy 2 cycles after row_param_en, idle after 20 cycles.
  - Response: row_param_en=4'hF for 1 cycle; row_param=64'hA5; layer_done 1 pulse 2 cycles after all rows idle; layer_cnt=1.
- Back-pressure: cfg_vld held while row_status=4'b0100 -> cfg_rdy stays 0; row_status->0 -> accept in that cycle.
- Start timeout: row 3 never goes busy -> start_err=1 after 15 WAIT_START cycles; FSM in IDLE; layer_cnt unchanged; next cfg accepted.
- Round-robin: row_wr_req=4'hF, src_vld high for 8 beats D0..D7 -> row_wr_vld sequence 1,2,4,8,1,2,4,8, each carrying its beat one cycle after accept.
- Sparse and dropped requests:
  - row_wr_req=4'b1010 with pointer 0 -> first beat to row 1, then row 3.
  - Drop req[3] with pointer 2 -> beat goes to row 1.
  - row_wr_req=0 with src_vld high -> src_rdy=0, no row_wr_vld.
- Async reset mid-RUN with a beat in flight -> all outputs 0 immediately; layer_cnt=0; pointer=0; state IDLE.
